muldiv_unit: RTL and testbench

//  Multi-cycle RV32M/RV64M multiply/divide unit alongside the single-cycle ALU in the execute stage.

---
 rtl/muldiv_unit.sv | 243 ++++++++++++++++++++++++
 tb/tb_muldiv_unit.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Multi-cycle RV32M/RV64M multiply/divide unit for the execute stage.
// Pipelined multiply (MUL_STAGES deep) and an iterative restoring divider.
// Optional feature macro: MULDIV_DIV_EN builds the divider; without it, ops 4..7
// retire after one cycle flagged by illegal_op_m with a zero result.
module muldiv_unit #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned MUL_STAGES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_e,
    input  logic [2:0]      op_e,
    input  logic [XLEN-1:0] src1_e,
    input  logic [XLEN-1:0] src2_e,
    input  logic [4:0]      rd_addr_e,
    input  logic            flush,
    output logic            stall_e,
    output logic            busy,
    output logic            done_m,
    output logic [XLEN-1:0] result_m,
    output logic [4:0]      rd_addr_m,
    output logic            illegal_op_m
);

    localparam int unsigned PIPE_DEPTH = (MUL_STAGES > 1) ? MUL_STAGES - 1 : 1;
    localparam int unsigned CNT_W      = $clog2(XLEN + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
`ifdef MULDIV_DIV_EN
        S_DIV,
`endif
        S_DONE
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [4:0]        rd_q;
    logic [XLEN-1:0]   mul_pipe [PIPE_DEPTH];
    logic              accept;
    logic              load_res;
    logic              illegal_nxt;
    logic [XLEN-1:0]   res_nxt;

    // Multiplier front end: sign-extend per op, keep the requested half.
    logic              a_sx;
    logic              b_sx;
    logic [2*XLEN-1:0] a_ext;
    logic [2*XLEN-1:0] b_ext;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   mul_c;

    assign accept = (state == S_IDLE) && start_e && !flush;

    // Operand conditioning and full-width product of the op held in E
    always_comb begin
        a_sx  = (op_e[1:0] != 2'd3) && src1_e[XLEN-1];
        b_sx  = (op_e[1:0] == 2'd1) && src2_e[XLEN-1];
        a_ext = {{XLEN{a_sx}}, src1_e};
        b_ext = {{XLEN{b_sx}}, src2_e};
        prod  = a_ext * b_ext;
        mul_c = (op_e[1:0] == 2'd0) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    end

`ifdef MULDIV_DIV_EN
    logic [XLEN-1:0] min_int;
    logic            div_signed;
    logic [XLEN-1:0] abs_a;
    logic [XLEN-1:0] abs_b;
    logic            special;
    logic [XLEN-1:0] special_res;
    logic [XLEN-1:0] rem_q;
    logic [XLEN-1:0] quo_q;
    logic [XLEN-1:0] div_b;
    logic            q_neg;
    logic            r_neg;
    logic            is_rem_q;
    logic [XLEN:0]   rem_sh;
    logic [XLEN:0]   diff;
    logic [XLEN-1:0] rem_nx;
    logic [XLEN-1:0] quo_nx;
    logic [XLEN-1:0] div_res;

    // Divider set-up: magnitudes and the one-cycle special cases
    always_comb begin
        min_int    = {1'b1, {(XLEN-1){1'b0}}};
        div_signed = !op_e[0];
        abs_a      = (div_signed && src1_e[XLEN-1]) ? XLEN'(0) - src1_e : src1_e;
        abs_b      = (div_signed && src2_e[XLEN-1]) ? XLEN'(0) - src2_e : src2_e;
        special    = 1'b0;
        special_res = '0;
        if (src2_e == '0) begin
            special     = 1'b1;
            special_res = op_e[1] ? src1_e : '1;
        end else if (div_signed && (src1_e == min_int) && (src2_e == '1)) begin
            special     = 1'b1;
            special_res = op_e[1] ? '0 : src1_e;
        end
    end

    // One restoring iteration plus the final sign fix of the result
    always_comb begin
        rem_sh = {rem_q, quo_q[XLEN-1]};
        diff   = rem_sh - {1'b0, div_b};
        if (!diff[XLEN]) begin
            rem_nx = diff[XLEN-1:0];
            quo_nx = {quo_q[XLEN-2:0], 1'b1};
        end else begin
            rem_nx = rem_sh[XLEN-1:0];
            quo_nx = {quo_q[XLEN-2:0], 1'b0};
        end
        if (is_rem_q) div_res = r_neg ? XLEN'(0) - rem_nx : rem_nx;
        else          div_res = q_neg ? XLEN'(0) - quo_nx : quo_nx;
    end

    // Divider working registers
    always_ff @(posedge clk) begin
        if (accept) begin
            rem_q    <= '0;
            quo_q    <= abs_a;
            div_b    <= abs_b;
            q_neg    <= div_signed && (src1_e[XLEN-1] ^ src2_e[XLEN-1]);
            r_neg    <= div_signed && src1_e[XLEN-1];
            is_rem_q <= op_e[1];
        end else if (state == S_DIV) begin
            rem_q <= rem_nx;
            quo_q <= quo_nx;
        end
    end
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next state and the result to retire on entry to DONE
    always_comb begin
        state_nxt   = state;
        load_res    = 1'b0;
        illegal_nxt = 1'b0;
        res_nxt     = '0;
        case (state)
            S_IDLE: begin
                if (start_e) begin
                    if (!op_e[2]) begin
                        if (MUL_STAGES == 1) begin
                            state_nxt = S_DONE;
                            load_res  = 1'b1;
                            res_nxt   = mul_c;
                        end else begin
                            state_nxt = S_MUL;
                        end
                    end else begin
`ifdef MULDIV_DIV_EN
                        if (special) begin
                            state_nxt = S_DONE;
                            load_res  = 1'b1;
                            res_nxt   = special_res;
                        end else begin
                            state_nxt = S_DIV;
                        end
`else
                        state_nxt   = S_DONE;
                        load_res    = 1'b1;
                        illegal_nxt = 1'b1;
`endif
                    end
                end
            end
            S_MUL: begin
                if (cnt == CNT_W'(MUL_STAGES - 2)) begin
                    state_nxt = S_DONE;
                    load_res  = 1'b1;
                    res_nxt   = mul_pipe[PIPE_DEPTH-1];
                end
            end
`ifdef MULDIV_DIV_EN
            S_DIV: begin
                if (cnt == CNT_W'(XLEN - 1)) begin
                    state_nxt = S_DONE;
                    load_res  = 1'b1;
                    res_nxt   = div_res;
                end
            end
`endif
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (flush) begin
            state_nxt   = S_IDLE;
            load_res    = 1'b0;
            illegal_nxt = 1'b0;
        end
    end

    // Pipeline stall request while the op is being worked on
    always_comb begin
        stall_e = !flush && (((state == S_IDLE) && start_e) || (state == S_MUL)
`ifdef MULDIV_DIV_EN
                  || (state == S_DIV)
`endif
                  );
    end

    // Cycle counter within MUL/DIV, restarted from IDLE
    always_ff @(posedge clk) begin
        if (rst || state == S_IDLE) cnt <= '0;
        else                        cnt <= cnt + CNT_W'(1);
    end

    // Multiplier pipeline and destination capture
    always_ff @(posedge clk) begin
        if (accept) begin
            rd_q        <= rd_addr_e;
            mul_pipe[0] <= mul_c;
        end
        for (int i = 1; i < int'(PIPE_DEPTH); i++) mul_pipe[i] <= mul_pipe[i-1];
    end

    // Registered outputs to M
    always_ff @(posedge clk) begin
        if (rst) begin
            busy         <= 1'b0;
            done_m       <= 1'b0;
            illegal_op_m <= 1'b0;
            result_m     <= '0;
            rd_addr_m    <= '0;
        end else begin
            busy         <= (state_nxt != S_IDLE);
            done_m       <= load_res;
            illegal_op_m <= illegal_nxt;
            if (load_res) begin
                result_m  <= res_nxt;
                rd_addr_m <= (state == S_IDLE) ? rd_addr_e : rd_q;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit (XLEN=32, MUL_STAGES=2).
// Expectations follow MULDIV_DIV_EN the same way the design build does.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_e;
    logic [2:0]  op_e;
    logic [31:0] src1_e;
    logic [31:0] src2_e;
    logic [4:0]  rd_addr_e;
    logic        flush;
    logic        stall_e;
    logic        busy;
    logic        done_m;
    logic [31:0] result_m;
    logic [4:0]  rd_addr_m;
    logic        illegal_op_m;

    int n_cmp = 0;
    int n_bad = 0;

    muldiv_unit #(.XLEN(32), .MUL_STAGES(2)) dut (
        .clk(clk), .rst(rst), .start_e(start_e), .op_e(op_e),
        .src1_e(src1_e), .src2_e(src2_e), .rd_addr_e(rd_addr_e), .flush(flush),
        .stall_e(stall_e), .busy(busy), .done_m(done_m), .result_m(result_m),
        .rd_addr_m(rd_addr_m), .illegal_op_m(illegal_op_m)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        int          lat;
    } vec_t;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Reference: RISC-V M-extension semantics using 64-bit arithmetic
    function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] res, output int lat, output logic ill);
        longint      sa;
        longint      sb;
        longint      q;
        longint      r;
        logic [63:0] p;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ill = 1'b0;
        lat = 2;
        res = '0;
        case (op)
            3'd0: begin p = 64'(sa * sb); res = p[31:0]; end
            3'd1: begin p = 64'(sa * sb); res = p[63:32]; end
            3'd2: begin p = 64'(sa * longint'({32'b0, b})); res = p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; res = p[63:32]; end
            default: begin
`ifdef MULDIV_DIV_EN
                if (b == 32'd0) begin
                    lat = 1;
                    res = op[1] ? a : 32'hFFFF_FFFF;
                end else if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    lat = 1;
                    res = op[1] ? 32'd0 : a;
                end else begin
                    lat = 33;
                    if (!op[0]) begin q = sa / sb; r = sa % sb; end
                    else begin q = longint'(a / b); r = longint'(a % b); end
                    res = op[1] ? r[31:0] : q[31:0];
                end
`else
                lat = 1;
                ill = 1'b1;
                res = '0;
`endif
            end
        endcase
    endfunction

    // Issue one op from IDLE, hold it in E until done_m, then return to IDLE
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, output logic [31:0] res, output int lat,
                          output logic ill, output logic [4:0] rdo, output logic stall_ok);
        logic seen;
        start_e   = 1'b1;
        op_e      = op;
        src1_e    = a;
        src2_e    = b;
        rd_addr_e = rd;
        #1;
        stall_ok = (stall_e === 1'b1);
        seen = 1'b0;
        lat  = -1;
        res  = 'x;
        ill  = 1'bx;
        rdo  = 'x;
        for (int cyc = 1; cyc <= 100 && !seen; cyc++) begin
            @(posedge clk); #1;
            if (done_m === 1'b1) begin
                seen = 1'b1;
                lat  = cyc;
                res  = result_m;
                ill  = illegal_op_m;
                rdo  = rd_addr_m;
                if (stall_e !== 1'b0) stall_ok = 1'b0;
                start_e = 1'b0;
            end else if (stall_e !== 1'b1 || busy !== 1'b1) begin
                stall_ok = 1'b0;
            end
        end
        start_e = 1'b0;
        if (!seen) $display("FAIL timeout: op %0d got no done_m expected one within 100 cycles", op);
        @(posedge clk); #1;
    endtask

    task automatic run_and_check(input string tag, input logic [2:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input logic [4:0] rd, input logic [31:0] eres,
                                 input int elat, input logic eill);
        logic [31:0] res;
        int          lat;
        logic        ill;
        logic [4:0]  rdo;
        logic        sok;
        run_op(op, a, b, rd, res, lat, ill, rdo, sok);
        check({tag, "_result"}, 64'(res), 64'(eres));
        check({tag, "_latency"}, 64'(lat), 64'(elat));
        check({tag, "_illegal"}, 64'(ill), 64'(eill));
        check({tag, "_rd"}, 64'(rdo), 64'(rd));
        check({tag, "_stall"}, 64'(sok), 64'd1);
    endtask

    initial begin
        vec_t        vecs [14];
        logic [31:0] eres;
        int          elat;
        logic        eill;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        done_seen;
        logic [2:0]  fl_op;
        int          fl_at;
        int          rs_at;

        vecs[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 2};
        vecs[1]  = '{3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 2};
        vecs[2]  = '{3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 2};
        vecs[3]  = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 2};
        vecs[4]  = '{3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 33};
        vecs[5]  = '{3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 33};
        vecs[6]  = '{3'd5, 32'd100,        32'd7,         32'd14,        33};
        vecs[7]  = '{3'd7, 32'd100,        32'd7,         32'd2,         33};
        vecs[8]  = '{3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF, 1};
        vecs[9]  = '{3'd7, 32'd5,          32'd0,         32'd5,         1};
        vecs[10] = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1};
        vecs[11] = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1};
        vecs[12] = '{3'd4, 32'd9,          32'd3,         32'd3,         33};
        vecs[13] = '{3'd0, 32'd3,          32'd3,         32'd9,         2};

        rst = 1'b1; start_e = 1'b0; op_e = '0; src1_e = '0; src2_e = '0;
        rd_addr_e = '0; flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_done", 64'(done_m), 64'd0);
        check("rst_illegal", 64'(illegal_op_m), 64'd0);
        check("rst_result", 64'(result_m), 64'd0);
        check("rst_rd", 64'(rd_addr_m), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_stall", 64'(stall_e), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed vectors
        for (int i = 0; i < 14; i++) begin
            eres = vecs[i].res;
            elat = vecs[i].lat;
            eill = 1'b0;
`ifndef MULDIV_DIV_EN
            if (vecs[i].op[2]) begin
                eres = '0;
                elat = 1;
                eill = 1'b1;
            end
`endif
            run_and_check($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                          5'(i + 1), eres, elat, eill);
        end

        // Randomized ops against the reference model
        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 9) == 0) begin
                a = 32'h8000_0000;
                b = 32'hFFFF_FFFF;
            end
            model(op, a, b, eres, elat, eill);
            run_and_check($sformatf("rnd%0d", i), op, a, b, 5'($urandom_range(0, 31)), eres, elat, eill);
        end

        // Flush of a start_e presented while IDLE: nothing is accepted
        start_e = 1'b1; op_e = 3'd0; src1_e = 32'd5; src2_e = 32'd5; rd_addr_e = 5'd3;
        flush = 1'b1;
        #1;
        check("idle_flush_stall", 64'(stall_e), 64'd0);
        @(posedge clk); #1;
        check("idle_flush_busy", 64'(busy), 64'd0);
        flush = 1'b0; start_e = 1'b0;
        @(posedge clk); #1;

        // Flush mid-operation, then a new MUL right behind it
`ifdef MULDIV_DIV_EN
        fl_op = 3'd4; fl_at = 10;
`else
        fl_op = 3'd0; fl_at = 1;
`endif
        start_e = 1'b1; op_e = fl_op; src1_e = 32'd100; src2_e = 32'd7; rd_addr_e = 5'd9;
        done_seen = 1'b0;
        for (int c = 1; c <= fl_at; c++) begin
            @(posedge clk); #1;
            if (done_m === 1'b1) done_seen = 1'b1;
        end
        flush = 1'b1;
        #1;
        check("flush_stall", 64'(stall_e), 64'd0);
        @(posedge clk); #1;
        flush = 1'b0; start_e = 1'b0;
        check("flush_no_done", 64'(done_seen | done_m), 64'd0);
        check("flush_busy", 64'(busy), 64'd0);
        run_and_check("after_flush", 3'd0, 32'd3, 32'd4, 5'd11, 32'd12, 2, 1'b0);

        // Reset in the middle of an operation clears everything
`ifdef MULDIV_DIV_EN
        fl_op = 3'd4; rs_at = 5;
`else
        fl_op = 3'd0; rs_at = 1;
`endif
        start_e = 1'b1; op_e = fl_op; src1_e = 32'd9; src2_e = 32'd3; rd_addr_e = 5'd17;
        for (int c = 1; c <= rs_at; c++) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_result", 64'(result_m), 64'd0);
        check("midrst_rd", 64'(rd_addr_m), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_done", 64'(done_m), 64'd0);
        check("midrst_illegal", 64'(illegal_op_m), 64'd0);
        rst = 1'b0; start_e = 1'b0;
        @(posedge clk); #1;
        run_and_check("after_rst", 3'd0, 32'd3, 32'd3, 5'd2, 32'd9, 2, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
